// File: rtl/inst_queue.sv
// Circular instruction FIFO between fetch and decode, flushed by ROB redirects.
// Optional macro INSTQUEUE_BYPASS_EN forwards a push straight to the decoder when the queue is empty.
module inst_queue #(
    parameter int DEPTH      = 16,
    parameter int INST_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  if_instqueue_en_in,
    input  logic [INST_WIDTH-1:0] if_instqueue_inst_in,
    input  logic [ADDR_WIDTH-1:0] if_instqueue_pc_in,
    output logic                  instqueue_if_rdy_out,
    input  logic                  decoder_instqueue_rdy_in,
    output logic                  instqueue_decoder_en_out,
    output logic [INST_WIDTH-1:0] instqueue_decoder_inst_out,
    output logic [ADDR_WIDTH-1:0] instqueue_decoder_pc_out,
    input  logic                  rob_instqueue_clear_in
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = INST_WIDTH + ADDR_WIDTH;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] RDY_MAX  = CW'(DEPTH - 2);

    logic [EW-1:0]         mem_q [DEPTH];
    logic [PW-1:0]         head_q, head_d;
    logic [PW-1:0]         tail_q, tail_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  en_q, en_d;
    logic [INST_WIDTH-1:0] inst_q, inst_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  wr_en;
    logic                  do_push;
    logic                  do_pop;
    logic                  bypass;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        en_d    = en_q;
        inst_d  = inst_q;
        pc_d    = pc_q;
        wr_en   = 1'b0;
        do_push = 1'b0;
        do_pop  = 1'b0;
        bypass  = 1'b0;
        if (rdy_in) begin
            en_d = 1'b0;
            if (rob_instqueue_clear_in) begin
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end else begin
`ifdef INSTQUEUE_BYPASS_EN
                bypass = (count_q == '0) && if_instqueue_en_in && decoder_instqueue_rdy_in;
`endif
                do_push = if_instqueue_en_in && (count_q < FULL_CNT) && !bypass;
                do_pop  = decoder_instqueue_rdy_in && (count_q != '0);
                if (bypass) begin
                    en_d   = 1'b1;
                    inst_d = if_instqueue_inst_in;
                    pc_d   = if_instqueue_pc_in;
                end
                // Pop reads the pre-edge head, so a same-cycle push is never returned here.
                if (do_pop) begin
                    en_d           = 1'b1;
                    {inst_d, pc_d} = mem_q[head_q];
                    head_d         = head_q + 1'b1;
                end
                if (do_push) begin
                    wr_en  = 1'b1;
                    tail_d = tail_q + 1'b1;
                end
                case ({do_push, do_pop})
                    2'b10:   count_d = count_q + 1'b1;
                    2'b01:   count_d = count_q - 1'b1;
                    default: count_d = count_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            en_q    <= 1'b0;
            inst_q  <= '0;
            pc_q    <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            en_q    <= en_d;
            inst_q  <= inst_d;
            pc_q    <= pc_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in && wr_en) begin
            mem_q[tail_q] <= {if_instqueue_inst_in, if_instqueue_pc_in};
        end
    end

    // One slot stays free for the push fetch may already have in flight.
    assign instqueue_if_rdy_out       = (count_q <= RDY_MAX);
    assign instqueue_decoder_en_out   = en_q;
    assign instqueue_decoder_inst_out = inst_q;
    assign instqueue_decoder_pc_out   = pc_q;

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: directed scenarios then random traffic against a queue model.
// Honours INSTQUEUE_BYPASS_EN the same way as the design.
module tb_inst_queue;

    localparam int DEPTH = 16;
    localparam int IW    = 32;
    localparam int AW    = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rdy;
    logic          push_en;
    logic [IW-1:0] push_inst;
    logic [AW-1:0] push_pc;
    logic          fetch_rdy;
    logic          dec_rdy;
    logic          dec_en;
    logic [IW-1:0] dec_inst;
    logic [AW-1:0] dec_pc;
    logic          clear;

    int vectors    = 0;
    int miscompares = 0;

    logic [IW+AW-1:0] model_q[$];
    logic             exp_en;
    logic [IW-1:0]    exp_inst;
    logic [AW-1:0]    exp_pc;

    inst_queue #(.DEPTH(DEPTH), .INST_WIDTH(IW), .ADDR_WIDTH(AW)) dut (
        .clk_in                     (clk),
        .rst_in                     (rst_n),
        .rdy_in                     (rdy),
        .if_instqueue_en_in         (push_en),
        .if_instqueue_inst_in       (push_inst),
        .if_instqueue_pc_in         (push_pc),
        .instqueue_if_rdy_out       (fetch_rdy),
        .decoder_instqueue_rdy_in   (dec_rdy),
        .instqueue_decoder_en_out   (dec_en),
        .instqueue_decoder_inst_out (dec_inst),
        .instqueue_decoder_pc_out   (dec_pc),
        .rob_instqueue_clear_in     (clear)
    );

    always #5 clk = ~clk;

    // Reference behaviour for one clock edge, using the inputs held across that edge.
    task automatic modelStep();
        logic [IW+AW-1:0] popped;
        int               pre_size;
        pre_size = model_q.size();
        if (!rst_n) begin
            model_q.delete();
            exp_en   = 1'b0;
            exp_inst = '0;
            exp_pc   = '0;
        end else if (!rdy) begin
            // frozen: nothing changes
        end else if (clear) begin
            model_q.delete();
            exp_en = 1'b0;
        end else begin
            exp_en = 1'b0;
`ifdef INSTQUEUE_BYPASS_EN
            if (pre_size == 0 && push_en && dec_rdy) begin
                exp_en   = 1'b1;
                exp_inst = push_inst;
                exp_pc   = push_pc;
                return;
            end
`endif
            if (dec_rdy && pre_size > 0) begin
                popped = model_q.pop_front();
                exp_en = 1'b1;
                {exp_inst, exp_pc} = popped;
            end
            if (push_en && pre_size < DEPTH) model_q.push_back({push_inst, push_pc});
        end
    endtask

    task automatic checkOutput(input string tag);
        logic exp_rdy;
        exp_rdy = (model_q.size() <= DEPTH - 2);
        vectors++;
        assert (dec_en === exp_en) else begin
            miscompares++;
            $error("[TB] FAIL %s en_out: got %b expected %b", tag, dec_en, exp_en);
        end
        vectors++;
        assert (dec_inst === exp_inst) else begin
            miscompares++;
            $error("[TB] FAIL %s inst_out: got %h expected %h", tag, dec_inst, exp_inst);
        end
        vectors++;
        assert (dec_pc === exp_pc) else begin
            miscompares++;
            $error("[TB] FAIL %s pc_out: got %h expected %h", tag, dec_pc, exp_pc);
        end
        vectors++;
        assert (fetch_rdy === exp_rdy) else begin
            miscompares++;
            $error("[TB] FAIL %s rdy_out: got %b expected %b (model count %0d)",
                   tag, fetch_rdy, exp_rdy, model_q.size());
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, then compare against the model.
    task automatic applyStimulus(input string tag, input logic r_n, input logic g_rdy,
                                 input logic p_en, input logic [AW-1:0] pc,
                                 input logic d_rdy, input logic clr);
        rst_n     = r_n;
        rdy       = g_rdy;
        push_en   = p_en;
        push_inst = $urandom;
        push_pc   = pc;
        dec_rdy   = d_rdy;
        clear     = clr;
        @(posedge clk);
        modelStep();
        #1;
        checkOutput(tag);
    endtask

    initial begin
        rst_n = 1'b0; rdy = 1'b1; push_en = 1'b0; push_inst = '0; push_pc = '0;
        dec_rdy = 1'b0; clear = 1'b0;
        exp_en = 1'b0; exp_inst = '0; exp_pc = '0;

        $display("[TB] reset");
        applyStimulus("reset0", 1'b0, 1'b1, 1'b1, 32'h1234, 1'b1, 1'b0);
        applyStimulus("reset1", 1'b0, 1'b1, 1'b1, 32'h5678, 1'b1, 1'b0);
        applyStimulus("post_reset", 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);

        $display("[TB] fill to full, then one dropped push");
        for (int k = 0; k < DEPTH + 1; k++)
            applyStimulus("fill", 1'b1, 1'b1, 1'b1, 32'(k * 4), 1'b0, 1'b0);
        for (int k = 0; k < DEPTH + 1; k++)
            applyStimulus("drain", 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);

        $display("[TB] wrap-around streaming");
        for (int k = 0; k < 20; k++)
            applyStimulus("wrap", 1'b1, 1'b1, 1'b1, 32'(32'h100 + k * 4), 1'b1, 1'b0);
        applyStimulus("wrap_tail", 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        applyStimulus("wrap_idle", 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);

        $display("[TB] push and pop together at count 3");
        for (int k = 0; k < 3; k++)
            applyStimulus("sim_fill", 1'b1, 1'b1, 1'b1, 32'(32'h300 + k * 4), 1'b0, 1'b0);
        applyStimulus("sim_pushpop", 1'b1, 1'b1, 1'b1, 32'h3F0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++)
            applyStimulus("sim_drain", 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);

        $display("[TB] clear with concurrent push and pop");
        for (int k = 0; k < 5; k++)
            applyStimulus("clr_fill", 1'b1, 1'b1, 1'b1, 32'(32'h400 + k * 4), 1'b0, 1'b0);
        applyStimulus("clear", 1'b1, 1'b1, 1'b1, 32'h200, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++)
            applyStimulus("clr_after", 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        applyStimulus("clear_empty", 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1);

        $display("[TB] freeze");
        applyStimulus("frz_fill", 1'b1, 1'b1, 1'b1, 32'h500, 1'b0, 1'b0);
        applyStimulus("frz_fill", 1'b1, 1'b1, 1'b1, 32'h504, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++)
            applyStimulus("freeze", 1'b1, 1'b0, 1'b1, 32'(32'h600 + k * 4), 1'b1, 1'b1);
        for (int k = 0; k < 3; k++)
            applyStimulus("frz_drain", 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);

        $display("[TB] empty-queue push with decoder ready");
        applyStimulus("bypass", 1'b1, 1'b1, 1'b1, 32'h40, 1'b1, 1'b0);
        applyStimulus("bypass_next", 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
        applyStimulus("bypass_idle", 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);

        $display("[TB] random traffic");
        for (int k = 0; k < 400; k++)
            applyStimulus("random",
                          ($urandom_range(0, 99) != 0),
                          ($urandom_range(0, 9) != 0),
                          ($urandom_range(0, 3) != 0),
                          $urandom,
                          ($urandom_range(0, 2) != 0),
                          ($urandom_range(0, 24) == 0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
